// File: rtl/fn_result_stage_if.sv
// Handshake/bus bundle between the function units, fn_result_stage and writeback.
interface fn_result_stage_if #(
    parameter int WIDTH = 32,
    parameter int NCLS  = 5,
    parameter int SELW  = 3,
    parameter int TAGW  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SELW-1:0]       in_class;
    logic [TAGW-1:0]       in_tag;
    logic [NCLS*WIDTH-1:0] cls_data;
    logic                  mc_start;
    logic                  mc_done;
    logic [WIDTH-1:0]      mc_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_result;
    logic [TAGW-1:0]       out_tag;
    logic                  out_zero;
    logic                  out_neg;
    logic                  out_err;

    // Stage side
    modport slave (
        input  in_valid, in_class, in_tag, cls_data, mc_done, mc_result, out_ready,
        output in_ready, mc_start, out_valid, out_result, out_tag, out_zero, out_neg, out_err
    );

    // Issue / function-unit / writeback side
    modport master (
        output in_valid, in_class, in_tag, cls_data, mc_done, mc_result, out_ready,
        input  in_ready, mc_start, out_valid, out_result, out_tag, out_zero, out_neg, out_err
    );
endinterface

// File: rtl/fn_result_stage.sv
// Execute-stage result select: picks a function-class result (or waits on the
// multi-cycle unit), tags it with zero/neg/err flags and queues it for writeback.
module fn_result_stage #(
    parameter int WIDTH    = 32,
    parameter int NCLS     = 5,
    parameter int SELW     = 3,
    parameter int TAGW     = 5,
    parameter int DEPTH    = 2,
    parameter int MC_EN    = 1,
    parameter int MC_CLASS = 4
) (
    input logic              clk,
    input logic              rst,
    fn_result_stage_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_MC, HOLD_MC} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAGW-1:0]  tag;
        logic             zero;
        logic             neg;
        logic             err;
    } entry_t;

    function automatic entry_t make_entry(input logic [WIDTH-1:0] r,
                                          input logic [TAGW-1:0] t,
                                          input logic e);
        entry_t x;
        x.result = r;
        x.tag    = t;
        x.zero   = (r == '0);
        x.neg    = r[WIDTH-1];
        x.err    = e;
        return x;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [TAGW-1:0]  mc_tag_q, mc_tag_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             mc_start_q, mc_start_d;

    logic [WIDTH-1:0] slot_sel;
    logic             illegal;
    logic             is_mc;
    logic             has_room;
    logic             accept;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;

    // Class decode: only the SELW class bits select a slot; codes >= NCLS are illegal
    always_comb begin
        slot_sel = '0;
        for (int k = 0; k < NCLS; k++) begin
            if (bus.in_class == SELW'(k)) slot_sel = bus.cls_data[k*WIDTH +: WIDTH];
        end
        illegal = (int'(bus.in_class) >= NCLS);
        is_mc   = (MC_EN != 0) && (bus.in_class == SELW'(MC_CLASS));
    end

    assign has_room     = (count_q < CW'(DEPTH));
    assign bus.in_ready = (state_q == IDLE) && has_room;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = (count_q != '0) && bus.out_ready;

    // Issue/multi-cycle FSM plus queue push/pop bookkeeping.
    // HOLD_MC covers an mc_done that finds the queue full; it keeps the result
    // until a slot frees up rather than dropping it.
    always_comb begin
        state_d    = state_q;
        mc_tag_d   = mc_tag_q;
        hold_d     = hold_q;
        mc_start_d = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mc) begin
                        mc_tag_d   = bus.in_tag;
                        mc_start_d = 1'b1;
                        state_d    = WAIT_MC;
                    end else begin
                        push       = 1'b1;
                        push_entry = make_entry(illegal ? '0 : slot_sel, bus.in_tag, illegal);
                    end
                end
            end
            WAIT_MC: begin
                if (bus.mc_done) begin
                    if (has_room) begin
                        push       = 1'b1;
                        push_entry = make_entry(bus.mc_result, mc_tag_q, 1'b0);
                        state_d    = IDLE;
                    end else begin
                        hold_d  = bus.mc_result;
                        state_d = HOLD_MC;
                    end
                end
            end
            HOLD_MC: begin
                if (has_room) begin
                    push       = 1'b1;
                    push_entry = make_entry(hold_q, mc_tag_q, 1'b0);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_d = mem_q;
        if (push) mem_d[wptr_q] = push_entry;
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Head of queue drives the outputs; everything reads 0 when empty
    always_comb begin
        head           = (count_q != '0) ? mem_q[rptr_q] : '0;
        bus.out_valid  = (count_q != '0);
        bus.out_result = head.result;
        bus.out_tag    = head.tag;
        bus.out_zero   = head.zero;
        bus.out_neg    = head.neg;
        bus.out_err    = head.err;
        bus.mc_start   = mc_start_q;
    end

    // State registers; reset abandons any in-flight multi-cycle op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mem_q      <= '{default: '0};
            mc_tag_q   <= '0;
            hold_q     <= '0;
            mc_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
            mc_tag_q   <= mc_tag_d;
            hold_q     <= hold_d;
            mc_start_q <= mc_start_d;
        end
    end
endmodule

// File: tb/tb_fn_result_stage.sv
// Bench for fn_result_stage: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_fn_result_stage;
    localparam int WIDTH = 32;
    localparam int NCLS  = 5;
    localparam int SELW  = 3;
    localparam int TAGW  = 5;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fn_result_stage_if #(.WIDTH(WIDTH), .NCLS(NCLS), .SELW(SELW), .TAGW(TAGW)) bus ();

    fn_result_stage #(
        .WIDTH(WIDTH), .NCLS(NCLS), .SELW(SELW), .TAGW(TAGW),
        .DEPTH(DEPTH), .MC_EN(1), .MC_CLASS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        z, n, e;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        z, n, e;
    } exp_t;

    function automatic exp_t mk(input logic [31:0] r, input logic [4:0] t, input logic err);
        exp_t x;
        x.res = r; x.tag = t; x.z = (r == 32'd0); x.n = r[31]; x.e = err;
        return x;
    endfunction

    logic [31:0] slots [NCLS];

    task automatic load_slots();
        for (int k = 0; k < NCLS; k++) bus.cls_data[k*WIDTH +: WIDTH] = slots[k];
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_class = '0; bus.in_tag = '0;
        bus.mc_done = 0; bus.mc_result = '0; bus.out_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic [4:0] t);
        bus.in_valid = 1'b1; bus.in_class = c; bus.in_tag = t;
    endtask

    vec_t   tbl [5];
    exp_t   q [$];
    exp_t   e;
    int     phase;
    logic [4:0]  mtag;
    logic [31:0] held;
    logic   exp_start, exp_ir, push;

    initial begin
        idle_inputs();
        bus.cls_data = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_bus", {bus.out_result, bus.out_tag, bus.out_zero, bus.out_neg, bus.out_err}, 0);
        chk("rst_mc_start", bus.mc_start, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Legacy classes plus one illegal code, out_ready held high
        tbl[0] = '{3'd0, 5'd1, 32'h12340000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 5'd2, 32'h00000010, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 5'd3, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 5'd4, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{3'd6, 5'd5, 32'h00000000, 1'b1, 1'b0, 1'b1};
        slots[0] = 32'h12340000; slots[1] = 32'h10; slots[2] = 32'hFFFFFFFE;
        slots[3] = 32'h0;        slots[4] = 32'hDEADBEEF;
        load_slots();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("vec_in_ready", bus.in_ready, 1);
            issue(tbl[i].cls, tbl[i].tag);
            @(negedge clk);
            chk("vec_out_valid", bus.out_valid, 1);
            chk("vec_out_result", bus.out_result, tbl[i].res);
            chk("vec_out_tag", bus.out_tag, tbl[i].tag);
            chk("vec_flags", {bus.out_zero, bus.out_neg, bus.out_err}, {tbl[i].z, tbl[i].n, tbl[i].e});
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("vec_drained", bus.out_valid, 0);

        // Backpressure: third issue waits until one pop frees a slot
        bus.out_ready = 1'b0;
        slots[2] = 32'h110; load_slots(); issue(3'd2, 5'd10);
        @(negedge clk);
        chk("bp_ready1", bus.in_ready, 1);
        slots[2] = 32'h111; load_slots(); issue(3'd2, 5'd11);
        @(negedge clk);
        chk("bp_full", bus.in_ready, 0);
        chk("bp_head0", bus.out_tag, 10);
        slots[2] = 32'h112; load_slots(); issue(3'd2, 5'd12);
        @(negedge clk);
        chk("bp_held", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_after_pop", bus.in_ready, 1);
        chk("bp_head1", bus.out_tag, 11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_third_in", bus.in_ready, 0);
        chk("bp_head1_res", bus.out_result, 32'h111);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_head2", {bus.out_tag, bus.out_result}, {5'd12, 32'h112});
        @(negedge clk);
        chk("bp_empty", bus.out_valid, 0);

        // Multi-cycle: done arrives three cycles after the start pulse
        issue(3'd4, 5'd7);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mc_start_hi", bus.mc_start, 1);
        chk("mc_busy0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mc_start_lo", bus.mc_start, 0);
            chk("mc_busy", bus.in_ready, 0);
        end
        bus.mc_done = 1'b1; bus.mc_result = 32'h80000000;
        @(negedge clk);
        bus.mc_done = 1'b0;
        chk("mc_out", {bus.out_valid, bus.out_tag, bus.out_result}, {1'b1, 5'd7, 32'h80000000});
        chk("mc_flags", {bus.out_zero, bus.out_neg, bus.out_err}, 3'b010);
        chk("mc_ready_back", bus.in_ready, 1);
        @(negedge clk);

        // Multi-cycle result lands behind a queued entry; stray done ignored
        bus.out_ready = 1'b0;
        slots[2] = 32'h5; load_slots(); issue(3'd2, 5'd1);
        @(negedge clk);
        issue(3'd4, 5'd9);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.mc_done = 1'b1; bus.mc_result = 32'h0;
        @(negedge clk);
        bus.mc_result = 32'hABC;
        chk("mcq_full", bus.in_ready, 0);
        @(negedge clk);
        bus.mc_done = 1'b0;
        chk("mcq_head", bus.out_tag, 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mcq_second", {bus.out_tag, bus.out_result, bus.out_zero}, {5'd9, 32'h0, 1'b1});
        @(negedge clk);
        chk("mcq_stray_dropped", bus.out_valid, 0);

        // Reset during WAIT_MC, then a late mc_done
        issue(3'd4, 5'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        do_reset();
        bus.mc_done = 1'b1; bus.mc_result = 32'h77;
        chk("rmo_valid", bus.out_valid, 0);
        chk("rmo_ready", bus.in_ready, 1);
        chk("rmo_start", bus.mc_start, 0);
        @(negedge clk);
        bus.mc_done = 1'b0;
        chk("rmo_nopush", bus.out_valid, 0);
        chk("rmo_ready2", bus.in_ready, 1);

        // Random traffic against the queue model
        idle_inputs();
        do_reset();
        q.delete(); phase = 0; exp_start = 0; mtag = '0; held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_ir = (phase == 0) && (q.size() < DEPTH);
            chk("r_in_ready", bus.in_ready, exp_ir);
            chk("r_mc_start", bus.mc_start, exp_start);
            chk("r_out_valid", bus.out_valid, q.size() > 0);
            if (q.size() > 0)
                chk("r_out", {bus.out_result, bus.out_tag, bus.out_zero, bus.out_neg, bus.out_err},
                    {q[0].res, q[0].tag, q[0].z, q[0].n, q[0].e});
            else
                chk("r_out_empty", {bus.out_result, bus.out_tag, bus.out_zero, bus.out_neg, bus.out_err}, 0);

            for (int k = 0; k < NCLS; k++) slots[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            load_slots();
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_class  = 3'($urandom_range(0, 7));
            bus.in_tag    = 5'($urandom);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.mc_done   = ($urandom_range(0, 3) == 0);
            bus.mc_result = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            rst           = ($urandom_range(0, 199) == 0);

            if (rst) begin
                q.delete(); phase = 0; exp_start = 0;
            end else begin
                push = 1'b0; exp_start = 1'b0; e = mk(32'd0, 5'd0, 1'b0);
                if (phase == 0) begin
                    if (bus.in_valid && exp_ir) begin
                        if (bus.in_class == 3'd4) begin
                            mtag = bus.in_tag; phase = 1; exp_start = 1'b1;
                        end else begin
                            push = 1'b1;
                            e = (bus.in_class >= NCLS) ? mk(32'd0, bus.in_tag, 1'b1)
                                                       : mk(slots[bus.in_class], bus.in_tag, 1'b0);
                        end
                    end
                end else if (phase == 1) begin
                    if (bus.mc_done) begin
                        if (q.size() < DEPTH) begin
                            push = 1'b1; e = mk(bus.mc_result, mtag, 1'b0); phase = 0;
                        end else begin
                            held = bus.mc_result; phase = 2;
                        end
                    end
                end else begin
                    if (q.size() < DEPTH) begin
                        push = 1'b1; e = mk(held, mtag, 1'b0); phase = 0;
                    end
                end
                if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
                if (push) q.push_back(e);
            end
            @(negedge clk);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
